// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART host controller: 16550-style register
// addresses, line-control bit positions, FIFO init value and FSM states.
package uart_ctrl_pkg;

    // Register addresses (THR and DLL share offset 0, selected by DLAB)
    localparam logic [2:0] ADDR_THR = 3'd0;
    localparam logic [2:0] ADDR_DLL = 3'd0;
    localparam logic [2:0] ADDR_DLM = 3'd1;
    localparam logic [2:0] ADDR_FCR = 3'd2;
    localparam logic [2:0] ADDR_LCR = 3'd3;

    // Divisor-latch access bit inside LCR
    localparam int DLAB_BIT = 7;

    // FIFO enable plus RX/TX FIFO clear
    localparam logic [7:0] FCR_INIT = 8'h07;

    // Line-control value reloaded at reset
    localparam logic [7:0] LCR_RST = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_C_DLAB = 3'd1,
        ST_C_DLL  = 3'd2,
        ST_C_DLM  = 3'd3,
        ST_C_LCR  = 3'd4,
        ST_C_FCR  = 3'd5,
        ST_READY  = 3'd6,
        ST_GAP    = 3'd7
    } host_state_e;

    // Line-control byte with the DLAB bit forced; the caller's bit 7 is ignored
    function automatic logic [7:0] lcr_with_dlab(input logic [7:0] lcr, input logic dlab);
        logic [7:0] v;
        v           = lcr;
        v[DLAB_BIT] = dlab;
        return v;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NREQ requesters. The requester
// just served becomes lowest priority once the grant is accepted.
module uart_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Index of the requester holding highest priority
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            sel;

    // Search upward from the pointer for the first active request
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        gnt   = '0;
        sel   = 0;
        ptr_d = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            // Descending scan: the last hit written is the closest to ptr_q
            if (req[(int'(ptr_q) + k) % NREQ]) begin
                sel = (int'(ptr_q) + k) % NREQ;
            end
        end
        if (req != '0) begin
            gnt[sel] = 1'b1;
        end
        if (accept && (req != '0)) begin
            ptr_d = PW'((sel + 1) % NREQ);
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// UART host controller: programs divisor and line control into a 16550-style
// UART, then multiplexes bytes from NREQ requesters into THR with a
// round-robin arbiter and a one-cycle gap after each push.
// Optional feature: define UART_HOST_CTRL_FCR_EN to add an FCR write
// (FIFO enable and clear) at the end of every configuration sequence.
module uart_host_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter logic [15:0] DIV_RST = 16'h0008
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_cfg,
    input  logic [15:0]       div,
    input  logic [7:0]        lcr,
    input  logic              tx_ready,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              uart_wr,
    output logic [2:0]        uart_addr,
    output logic [7:0]        uart_din,
    output logic              cfg_done,
    output logic              busy
);

    host_state_e     state_q, state_d;
    logic [15:0]     div_q, div_d;
    logic [7:0]      lcr_q, lcr_d;
    logic            cfg_done_q, cfg_done_d;

    logic            accept;
    logic [NREQ-1:0] arb_gnt;
    logic [7:0]      sel_data;

    uart_rr_arbiter #(
        .NREQ   (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (arb_gnt)
    );

    // Byte of the requester the arbiter currently favours
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = sel_data | req_data[8*i +: 8];
            end
        end
    end

    // Next-state logic and the single register write issued each cycle
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        lcr_d     = lcr_q;
        accept    = 1'b0;
        uart_wr   = 1'b0;
        uart_addr = '0;
        uart_din  = '0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_cfg) begin
                    div_d   = div;
                    lcr_d   = lcr;
                    state_d = ST_C_DLAB;
                end
            end
            ST_C_DLAB: begin
                busy      = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = ADDR_LCR;
                uart_din  = lcr_with_dlab(lcr_q, 1'b1);
                state_d   = ST_C_DLL;
            end
            ST_C_DLL: begin
                busy      = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = ADDR_DLL;
                uart_din  = div_q[7:0];
                state_d   = ST_C_DLM;
            end
            ST_C_DLM: begin
                busy      = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = ADDR_DLM;
                uart_din  = div_q[15:8];
                state_d   = ST_C_LCR;
            end
            ST_C_LCR: begin
                busy      = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = ADDR_LCR;
                uart_din  = lcr_with_dlab(lcr_q, 1'b0);
`ifdef UART_HOST_CTRL_FCR_EN
                state_d   = ST_C_FCR;
`else
                state_d   = ST_READY;
`endif
            end
`ifdef UART_HOST_CTRL_FCR_EN
            ST_C_FCR: begin
                busy      = 1'b1;
                uart_wr   = 1'b1;
                uart_addr = ADDR_FCR;
                uart_din  = FCR_INIT;
                state_d   = ST_READY;
            end
`endif
            ST_READY: begin
                if (tx_ready && (req != '0)) begin
                    accept    = 1'b1;
                    uart_wr   = 1'b1;
                    uart_addr = ADDR_THR;
                    uart_din  = sel_data;
                    state_d   = ST_GAP;
                end
                // Reconfiguration wins the next state; a write above still completes
                if (start_cfg) begin
                    div_d   = div;
                    lcr_d   = lcr;
                    state_d = ST_C_DLAB;
                end
            end
            ST_GAP: begin
                if (start_cfg) begin
                    div_d   = div;
                    lcr_d   = lcr;
                    state_d = ST_C_DLAB;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cfg_done_d = (state_d == ST_READY) || (state_d == ST_GAP);
    end

    // Grant pulses only when the byte is actually written
    always_comb begin
        gnt = accept ? arb_gnt : '0;
    end

    assign cfg_done = cfg_done_q;

    // State, captured configuration and completion flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            div_q      <= DIV_RST;
            lcr_q      <= LCR_RST;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            lcr_q      <= lcr_d;
            cfg_done_q <= cfg_done_d;
        end
    end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_uart_host_ctrl;

    localparam int          NREQ    = 2;
    localparam logic [15:0] DIV_RST = 16'h0008;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_cfg;
    logic [15:0]       div;
    logic [7:0]        lcr;
    logic              tx_ready;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              uart_wr;
    logic [2:0]        uart_addr;
    logic [7:0]        uart_din;
    logic              cfg_done;
    logic              busy;

    int checks = 0;
    int errors = 0;

    // Reference model: pending config writes as {addr, data}, completion
    // flag, gap-after-push flag and last requester served
    logic [10:0] m_cfg[$];
    bit          m_done;
    bit          m_gap;
    int          m_last;

    uart_host_ctrl #(
        .NREQ      (NREQ),
        .DIV_RST   (DIV_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_cfg (start_cfg),
        .div       (div),
        .lcr       (lcr),
        .tx_ready  (tx_ready),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .uart_wr   (uart_wr),
        .uart_addr (uart_addr),
        .uart_din  (uart_din),
        .cfg_done  (cfg_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cfg.delete();
        m_done = 1'b0;
        m_gap  = 1'b0;
        m_last = NREQ - 1;
    endtask

    task automatic model_load(input logic [15:0] d, input logic [7:0] l);
        m_cfg.delete();
        m_cfg.push_back({3'd3, 1'b1, l[6:0]});
        m_cfg.push_back({3'd0, d[7:0]});
        m_cfg.push_back({3'd1, d[15:8]});
        m_cfg.push_back({3'd3, 1'b0, l[6:0]});
`ifdef UART_HOST_CTRL_FCR_EN
        m_cfg.push_back({3'd2, 8'h07});
`endif
    endtask

    // Called at a falling edge with inputs already applied; checks this
    // cycle's outputs, then advances the model across the rising edge
    task automatic tick(input string tag);
        logic            e_wr, e_busy, e_done;
        logic [2:0]      e_addr;
        logic [7:0]      e_din;
        logic [NREQ-1:0] e_gnt;
        int              pick;
        int              idx;
        bit              in_cfg;

        #1;
        e_wr   = 1'b0;
        e_addr = '0;
        e_din  = '0;
        e_gnt  = '0;
        e_busy = 1'b0;
        e_done = m_done;
        pick   = -1;
        in_cfg = (m_cfg.size() > 0);

        if (in_cfg) begin
            e_wr   = 1'b1;
            e_addr = m_cfg[0][10:8];
            e_din  = m_cfg[0][7:0];
            e_busy = 1'b1;
            e_done = 1'b0;
        end else if (m_done && !m_gap && tx_ready && (req != '0)) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (pick < 0 && req[idx]) pick = idx;
            end
            e_wr        = 1'b1;
            e_din       = req_data[8*pick +: 8];
            e_gnt[pick] = 1'b1;
        end

        check({tag, ".uart_wr"},   32'(uart_wr),   32'(e_wr));
        check({tag, ".uart_addr"}, 32'(uart_addr), 32'(e_addr));
        check({tag, ".uart_din"},  32'(uart_din),  32'(e_din));
        check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
        check({tag, ".cfg_done"},  32'(cfg_done),  32'(e_done));
        check({tag, ".busy"},      32'(busy),      32'(e_busy));

        @(posedge clk);
        if (in_cfg) begin
            void'(m_cfg.pop_front());
            if (m_cfg.size() == 0) begin
                m_done = 1'b1;
                m_gap  = 1'b0;
            end
        end else begin
            if (pick >= 0) begin
                m_last = pick;
                m_gap  = 1'b1;
            end else begin
                m_gap = 1'b0;
            end
            if (start_cfg) begin
                model_load(div, lcr);
                m_done = 1'b0;
                m_gap  = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Assert reset at a falling edge, check outputs clear at once, release later
    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check({tag, ".uart_wr"},   32'(uart_wr),   32'd0);
        check({tag, ".uart_addr"}, 32'(uart_addr), 32'd0);
        check({tag, ".uart_din"},  32'(uart_din),  32'd0);
        check({tag, ".gnt"},       32'(gnt),       32'd0);
        check({tag, ".cfg_done"},  32'(cfg_done),  32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        start_cfg = 1'b0;
        div       = '0;
        lcr       = '0;
        tx_ready  = 1'b0;
        req       = '0;
        req_data  = '0;

        // Reset state
        apply_reset("reset");

        // Requests before configuration are never granted
        tx_ready = 1'b1;
        req      = 2'b11;
        req_data = 16'h1122;
        repeat (3) tick("pre_cfg");

        // Configuration sequence with div=0108, lcr=0C
        req       = '0;
        start_cfg = 1'b1;
        div       = 16'h0108;
        lcr       = 8'h0C;
        tick("cfg_start");
        start_cfg = 1'b0;
        tick("cfg_dlab");
        // start_cfg during a config state is ignored
        start_cfg = 1'b1;
        div       = 16'hFFFF;
        lcr       = 8'hFF;
        tick("cfg_dll");
        start_cfg = 1'b0;
        repeat (4) tick("cfg_rest");

        // Two requesters, round-robin with a gap after each push
        req      = 2'b11;
        req_data = {8'h3C, 8'hA5};
        repeat (4) tick("rr");

        // tx_ready low holds everything off, then the write goes through
        req      = 2'b01;
        tx_ready = 1'b0;
        repeat (10) tick("stall");
        tx_ready = 1'b1;
        repeat (2) tick("unstall");

        // Reconfiguration in READY with a byte pending
        req       = 2'b10;
        req_data  = {8'h5A, 8'h00};
        start_cfg = 1'b1;
        div       = 16'h1234;
        lcr       = 8'h9B;
        tick("recfg");
        start_cfg = 1'b0;
        repeat (7) tick("recfg_seq");

        // Reset in the middle of a configuration sequence
        req       = '0;
        start_cfg = 1'b1;
        div       = 16'h00C3;
        lcr       = 8'h07;
        tick("mid_start");
        start_cfg = 1'b0;
        tick("mid_dlab");
        tick("mid_dll");
        apply_reset("mid_reset");
        req      = 2'b11;
        tx_ready = 1'b1;
        repeat (4) tick("post_reset");
        start_cfg = 1'b1;
        tick("post_restart");
        start_cfg = 1'b0;
        repeat (8) tick("post_seq");

        // Randomized traffic with occasional reconfiguration
        for (int n = 0; n < 500; n++) begin
            start_cfg = ($urandom_range(0, 39) == 0);
            tx_ready  = ($urandom_range(0, 3) != 0);
            req       = NREQ'($urandom);
            req_data  = (8*NREQ)'($urandom);
            div       = 16'($urandom);
            lcr       = 8'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
